// File: rtl/if2id_queue.sv
// IF->ID stage buffer: DEPTH-entry circular queue of {inst, inst_addr, int_flag} with
// valid/ready on both sides, decode hold and synchronous flush. Optional macro: IF2ID_QUEUE_BYPASS_EN.

`ifndef Hold_Flag_Bus
`define Hold_Flag_Bus 2:0
`endif
`ifndef Hold_If
`define Hold_If 3'b010
`endif
`ifndef INST_NOP
`define INST_NOP 32'h00000001
`endif
`ifndef INT_NONE
`define INT_NONE 8'h0
`endif

module if2id_queue #(
    parameter int unsigned INST_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INT_W  = 8,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic [`Hold_Flag_Bus] hold_flag_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [INST_W-1:0]    inst_i,
    input  logic [ADDR_W-1:0]    inst_addr_i,
    input  logic [INT_W-1:0]     int_flag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [INST_W-1:0]    inst_o,
    output logic [ADDR_W-1:0]    inst_addr_o,
    output logic [INT_W-1:0]     int_flag_o,
    output logic [CNT_W-1:0]     count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [INT_W-1:0]  flag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    logic full;
    logic empty;
    logic hold_en;
    logic push;
    logic pop;
    logic bypass;
    logic wr_en;
    logic rd_en;

    // Handshake and queue control; bypass only steers the head when the queue is empty
    always_comb begin
        full       = (cnt == CNT_W'(DEPTH));
        empty      = (cnt == '0);
        hold_en    = (hold_flag_i >= `Hold_If);
        in_ready_o = !full && !flush_i;
        push       = in_valid_i && in_ready_o;
`ifdef IF2ID_QUEUE_BYPASS_EN
        bypass      = empty && !flush_i;
        out_valid_o = bypass ? in_valid_i : (!empty && !flush_i);
`else
        bypass      = 1'b0;
        out_valid_o = !empty && !flush_i;
`endif
        pop   = out_valid_o && out_ready_i && !hold_en;
        // A bypassed entry consumed in the same cycle never touches storage
        wr_en = push && !(bypass && pop);
        rd_en = pop && !bypass;
    end

    // Head presentation: NOP bubble whenever nothing valid is offered
    always_comb begin
        inst_o      = INST_W'(`INST_NOP);
        inst_addr_o = '0;
        int_flag_o  = INT_W'(`INT_NONE);
        if (out_valid_o) begin
            if (bypass) begin
                inst_o      = inst_i;
                inst_addr_o = inst_addr_i;
                int_flag_o  = int_flag_i;
            end else begin
                inst_o      = inst_mem[rd_ptr];
                inst_addr_o = addr_mem[rd_ptr];
                int_flag_o  = flag_mem[rd_ptr];
            end
        end
    end

    // Payload storage needs no reset: reads are masked until an entry is written
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            inst_mem[wr_ptr] <= inst_i;
            addr_mem[wr_ptr] <= inst_addr_i;
            flag_mem[wr_ptr] <= int_flag_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign count_o = cnt;

endmodule

// File: tb/tb_if2id_queue.sv
// Directed self-checking bench for if2id_queue (DEPTH=4); the bypass scenario runs when
// IF2ID_QUEUE_BYPASS_EN is defined for the whole compile.

module tb_if2id_queue;

    localparam logic [31:0] NOP     = 32'h00000001;
    localparam logic [2:0]  HOLD_NO = 3'b000;
    localparam logic [2:0]  HOLD_ID = 3'b011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [2:0]  hold_flag_i = HOLD_NO;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] inst_i = '0;
    logic [31:0] inst_addr_i = '0;
    logic [7:0]  int_flag_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic [7:0]  int_flag_o;
    logic [2:0]  count_o;

    int tests_run = 0;
    int tests_failed = 0;

    if2id_queue dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .hold_flag_i (hold_flag_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .int_flag_i  (int_flag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .inst_o      (inst_o),
        .inst_addr_o (inst_addr_o),
        .int_flag_o  (int_flag_o),
        .count_o     (count_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] addr,
                         input logic [7:0] flg);
        in_valid_i  = v;
        inst_i      = inst;
        inst_addr_i = addr;
        int_flag_i  = flg;
    endtask

    initial begin
        // Reset then idle
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_eq("rst_out_valid", 64'(out_valid_o), 64'(0));
        check_eq("rst_inst", 64'(inst_o), 64'(NOP));
        check_eq("rst_addr", 64'(inst_addr_o), 64'(0));
        check_eq("rst_flag", 64'(int_flag_o), 64'(0));
        check_eq("rst_count", 64'(count_o), 64'(0));
        check_eq("rst_in_ready", 64'(in_ready_o), 64'(1));

`ifdef IF2ID_QUEUE_BYPASS_EN
        // Bypass: empty queue forwards the input in the same cycle
        out_ready_i = 1'b1;
        drive(1'b1, 32'h00200113, 32'h8, 8'h0);
        #1;
        check_eq("byp_valid", 64'(out_valid_o), 64'(1));
        check_eq("byp_inst", 64'(inst_o), 64'(32'h00200113));
        check_eq("byp_addr", 64'(inst_addr_o), 64'(32'h8));
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
        check_eq("byp_count", 64'(count_o), 64'(0));
        // Not consumed (hold): entry is written and stays at the head
        hold_flag_i = HOLD_ID;
        drive(1'b1, 32'h000000AA, 32'hC, 8'h5);
        #1;
        check_eq("byp_hold_inst", 64'(inst_o), 64'(32'hAA));
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
        check_eq("byp_hold_count", 64'(count_o), 64'(1));
        check_eq("byp_hold_head", 64'(inst_addr_o), 64'(32'hC));
        hold_flag_i = HOLD_NO;
        tick();
        check_eq("byp_drain", 64'(count_o), 64'(0));
`else
        // Stream two instructions with the IDU ready: one-cycle latency, occupancy <= 1
        out_ready_i = 1'b1;
        drive(1'b1, 32'h00000013, 32'h0, 8'h0);
        #1;
        check_eq("lat_no_bypass", 64'(out_valid_o), 64'(0));
        tick();
        drive(1'b1, 32'h00100093, 32'h4, 8'h0);
        #1;
        check_eq("lat_a_inst", 64'(inst_o), 64'(32'h00000013));
        check_eq("lat_a_addr", 64'(inst_addr_o), 64'(32'h0));
        check_eq("lat_a_count", 64'(count_o), 64'(1));
        tick();
        drive(1'b0, '0, '0, '0);
        #1;
        check_eq("lat_b_inst", 64'(inst_o), 64'(32'h00100093));
        check_eq("lat_b_addr", 64'(inst_addr_o), 64'(32'h4));
        check_eq("lat_b_count", 64'(count_o), 64'(1));
        tick();
        check_eq("lat_empty_valid", 64'(out_valid_o), 64'(0));
        check_eq("lat_empty_inst", 64'(inst_o), 64'(NOP));
        check_eq("lat_empty_count", 64'(count_o), 64'(0));
`endif

        // Hold: five pushes into a four-entry queue, head frozen on the first
        hold_flag_i = HOLD_ID;
        out_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 32'h40 + 32'(4 * i), 8'(i + 1));
            #1;
            if (i > 0) check_eq("hold_head", 64'(inst_o), 64'(32'h100));
            if (i == 4) check_eq("hold_full_ready", 64'(in_ready_o), 64'(0));
            tick();
        end
        drive(1'b0, '0, '0, '0);
        #1;
        check_eq("hold_count", 64'(count_o), 64'(4));
        hold_flag_i = HOLD_NO;
        for (int j = 0; j < 4; j++) begin
            #1;
            check_eq("rel_valid", 64'(out_valid_o), 64'(1));
            check_eq("rel_inst", 64'(inst_o), 64'(32'h100 + 32'(j)));
            check_eq("rel_addr", 64'(inst_addr_o), 64'(32'h40 + 32'(4 * j)));
            check_eq("rel_flag", 64'(int_flag_o), 64'(j + 1));
            tick();
        end
        check_eq("rel_count", 64'(count_o), 64'(0));
        check_eq("rel_fifth_dropped", 64'(out_valid_o), 64'(0));

        // Flush with three queued and a push in flight
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 32'h80 + 32'(4 * i), 8'h0);
            tick();
        end
        check_eq("fl_pre_count", 64'(count_o), 64'(3));
        flush_i = 1'b1;
        out_ready_i = 1'b1;
        drive(1'b1, 32'hDEAD, 32'hF0, 8'h3);
        #1;
        check_eq("fl_cycle_valid", 64'(out_valid_o), 64'(0));
        check_eq("fl_cycle_inst", 64'(inst_o), 64'(NOP));
        check_eq("fl_cycle_ready", 64'(in_ready_o), 64'(0));
        tick();
        flush_i = 1'b0;
        drive(1'b0, '0, '0, '0);
        #1;
        check_eq("fl_count", 64'(count_o), 64'(0));
        check_eq("fl_valid", 64'(out_valid_o), 64'(0));
        check_eq("fl_inst", 64'(inst_o), 64'(NOP));
        tick();
        check_eq("fl_never_appears", 64'(out_valid_o), 64'(0));

        // Wrap: steady push/pop at occupancy 2 across several pointer wraps
        out_ready_i = 1'b0;
        drive(1'b1, 32'h300, 32'h0, 8'h0);
        tick();
        drive(1'b1, 32'h304, 32'h4, 8'h0);
        tick();
        out_ready_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h308 + 32'(4 * k), 32'h8 + 32'(4 * k), 8'h0);
            #1;
            check_eq("wrap_addr", 64'(inst_addr_o), 64'(32'(4 * k)));
            check_eq("wrap_inst", 64'(inst_o), 64'(32'h300 + 32'(4 * k)));
            check_eq("wrap_count", 64'(count_o), 64'(2));
            tick();
        end
        drive(1'b0, '0, '0, '0);
        #1;
        check_eq("wrap_tail0", 64'(inst_addr_o), 64'(32'h28));
        tick();
        check_eq("wrap_tail1", 64'(inst_addr_o), 64'(32'h2C));
        check_eq("wrap_tail1_count", 64'(count_o), 64'(1));
        tick();
        check_eq("wrap_drained", 64'(count_o), 64'(0));

        // Mid-operation reset, asserted together with flush and a push
        out_ready_i = 1'b0;
        drive(1'b1, 32'h400, 32'h100, 8'h7);
        tick();
        tick();
        rst = 1'b1;
        flush_i = 1'b1;
        tick();
        rst = 1'b0;
        flush_i = 1'b0;
        drive(1'b0, '0, '0, '0);
        #1;
        check_eq("mrst_count", 64'(count_o), 64'(0));
        check_eq("mrst_valid", 64'(out_valid_o), 64'(0));
        check_eq("mrst_inst", 64'(inst_o), 64'(NOP));
        check_eq("mrst_ready", 64'(in_ready_o), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
